// File: rtl/palette_wr_arbiter.sv
// Write-port arbiter for the 256x16 palette RAM: host byte writes take priority,
// the range-fill engine consumes every remaining cycle. All outputs registered.
module palette_wr_arbiter (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        host_req_i,
    input  logic [8:0]  host_addr_i,
    input  logic [7:0]  host_wdata_i,
    output logic        host_ack_o,
    input  logic        fill_start_i,
    input  logic [7:0]  fill_first_i,
    input  logic [7:0]  fill_last_i,
    input  logic [15:0] fill_value_i,
    output logic        fill_busy_o,
    output logic        fill_done_o,
    output logic        pal_wr_en_o,
    output logic [1:0]  pal_ben_o,
    output logic [7:0]  pal_wr_addr_o,
    output logic [15:0] pal_wr_data_o
);

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cur, r_last;
    logic [15:0] r_val;
    logic        r_ack, r_busy, r_done, r_wr_en;
    logic [1:0]  r_ben;
    logic [7:0]  r_addr;
    logic [15:0] r_data;

    logic        w_host_acc, w_start, w_fill_wr, w_last_hit;
    logic [7:0]  w_fill_addr, w_fill_last, w_cur_nxt;
    logic [15:0] w_fill_val;

    assign w_host_acc = host_req_i & ~r_ack;
    // Start is gated by the busy output so the final-write cycle cannot relaunch.
    assign w_start    = (r_state == S_IDLE) & fill_start_i & ~r_busy;

    // The first entry is written on the start edge itself, using the live range inputs.
    always_comb begin
        w_state_nxt = r_state;
        w_fill_wr   = 1'b0;
        w_fill_addr = r_cur;
        w_fill_last = r_last;
        w_fill_val  = r_val;
        w_cur_nxt   = r_cur;
        w_last_hit  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_FILL;
                    w_fill_addr = fill_first_i;
                    w_fill_last = fill_last_i;
                    w_fill_val  = fill_value_i;
                    w_cur_nxt   = fill_first_i;
                    w_fill_wr   = ~w_host_acc;
                end
            end
            S_FILL: w_fill_wr = ~w_host_acc;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_fill_wr) begin
            w_last_hit = (w_fill_addr == w_fill_last);
            w_cur_nxt  = w_fill_addr + 8'd1;
            if (w_last_hit) w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_last  <= '0;
            r_val   <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wr_en <= 1'b0;
            r_ben   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            if (w_start) begin
                r_last <= fill_last_i;
                r_val  <= fill_value_i;
            end
            r_ack   <= w_host_acc;
            r_busy  <= (w_state_nxt == S_FILL) | w_fill_wr;
            r_done  <= w_fill_wr & w_last_hit;
            r_wr_en <= w_host_acc | w_fill_wr;
            r_ben   <= 2'b00;
            if (w_host_acc) begin
                r_ben  <= host_addr_i[0] ? 2'b10 : 2'b01;
                r_addr <= host_addr_i[8:1];
                r_data <= {host_wdata_i, host_wdata_i};
            end else if (w_fill_wr) begin
                r_ben  <= 2'b11;
                r_addr <= w_fill_addr;
                r_data <= w_fill_val;
            end
        end
    end

    assign host_ack_o    = r_ack;
    assign fill_busy_o   = r_busy;
    assign fill_done_o   = r_done;
    assign pal_wr_en_o   = r_wr_en;
    assign pal_ben_o     = r_ben;
    assign pal_wr_addr_o = r_addr;
    assign pal_wr_data_o = r_data;

endmodule

// File: tb/tb_palette_wr_arbiter.sv
// Scoreboard bench for palette_wr_arbiter: a queue-based reference model predicts
// every palette write; a negedge monitor pops and compares whatever the DUT emits.
module tb_palette_wr_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        host_req_i;
    logic [8:0]  host_addr_i;
    logic [7:0]  host_wdata_i;
    logic        host_ack_o;
    logic        fill_start_i;
    logic [7:0]  fill_first_i;
    logic [7:0]  fill_last_i;
    logic [15:0] fill_value_i;
    logic        fill_busy_o;
    logic        fill_done_o;
    logic        pal_wr_en_o;
    logic [1:0]  pal_ben_o;
    logic [7:0]  pal_wr_addr_o;
    logic [15:0] pal_wr_data_o;

    palette_wr_arbiter dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .host_req_i(host_req_i), .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
        .host_ack_o(host_ack_o),
        .fill_start_i(fill_start_i), .fill_first_i(fill_first_i), .fill_last_i(fill_last_i),
        .fill_value_i(fill_value_i), .fill_busy_o(fill_busy_o), .fill_done_o(fill_done_o),
        .pal_wr_en_o(pal_wr_en_o), .pal_ben_o(pal_ben_o), .pal_wr_addr_o(pal_wr_addr_o),
        .pal_wr_data_o(pal_wr_data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [1:0]  ben;
        logic [15:0] data;
        logic        ack;
        logic        done;
    } wr_t;

    wr_t  exp_q[$];
    int   q_fill[$];
    logic exp_busy[int];
    logic [15:0] m_val;
    bit   m_ack, m_busy;
    int   cyc = 0;
    bit   mon_en = 0;
    int   n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: predicts what appears on the outputs in cycle cyc+1.
    task automatic model_step();
        bit  acc;
        int  n;
        wr_t e;
        bit  fw;
        acc = host_req_i && !m_ack;
        fw  = 0;
        if (!m_busy && fill_start_i) begin
            n = ((int'(fill_last_i) - int'(fill_first_i)) & 255) + 1;
            for (int i = 0; i < n; i++) q_fill.push_back((int'(fill_first_i) + i) & 255);
            m_val = fill_value_i;
        end
        e.cyc = cyc + 1;
        if (acc) begin
            e.addr = host_addr_i[8:1];
            e.ben  = host_addr_i[0] ? 2'b10 : 2'b01;
            e.data = {host_wdata_i, host_wdata_i};
            e.ack  = 1'b1;
            e.done = 1'b0;
            exp_q.push_back(e);
        end else if (q_fill.size() > 0) begin
            e.addr = 8'(q_fill.pop_front());
            e.ben  = 2'b11;
            e.data = m_val;
            e.ack  = 1'b0;
            e.done = (q_fill.size() == 0);
            exp_q.push_back(e);
            fw = 1;
        end
        m_ack  = acc;
        m_busy = (q_fill.size() > 0) || fw;
        exp_busy[cyc + 1] = m_busy;
    endtask

    task automatic step(input bit req, input logic [8:0] a, input logic [7:0] d,
                        input bit st, input logic [7:0] f, input logic [7:0] l,
                        input logic [15:0] v);
        host_req_i = req; host_addr_i = a; host_wdata_i = d;
        fill_start_i = st; fill_first_i = f; fill_last_i = l; fill_value_i = v;
        model_step();
        @(posedge clk_i); #1; cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 9'h0, 8'h0, 0, 8'h0, 8'h0, 16'h0);
    endtask

    task automatic fill(input logic [7:0] f, input logic [7:0] l, input logic [15:0] v);
        step(0, 9'h0, 8'h0, 1, f, l, v);
    endtask

    task automatic do_reset();
        mon_en = 0;
        host_req_i = 0; fill_start_i = 0;
        #3 rst_n_i = 0;
        #1;
        chk("rst_ack", {31'b0, host_ack_o}, 0);
        chk("rst_busy", {31'b0, fill_busy_o}, 0);
        chk("rst_done", {31'b0, fill_done_o}, 0);
        chk("rst_wr_en", {31'b0, pal_wr_en_o}, 0);
        chk("rst_ben", {30'b0, pal_ben_o}, 0);
        chk("rst_addr", {24'b0, pal_wr_addr_o}, 0);
        chk("rst_data", {16'b0, pal_wr_data_o}, 0);
        exp_q.delete(); q_fill.delete(); exp_busy.delete();
        m_ack = 0; m_busy = 0;
        repeat (2) begin @(posedge clk_i); #1; cyc++; end
        rst_n_i = 1;
        mon_en = 1;
    endtask

    always @(negedge clk_i) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_chk++; n_fail++;
                $display("FAIL missing_write @cyc %0d: no write on port, expected addr %h in cycle %0d",
                         cyc, exp_q[0].addr, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (pal_wr_en_o) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_write @cyc %0d: got addr %h, expected no write",
                             cyc, pal_wr_addr_o);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_cycle", cyc, e.cyc);
                    chk("wr_addr", {24'b0, pal_wr_addr_o}, {24'b0, e.addr});
                    chk("wr_ben", {30'b0, pal_ben_o}, {30'b0, e.ben});
                    chk("wr_data", {16'b0, pal_wr_data_o}, {16'b0, e.data});
                    chk("wr_ack", {31'b0, host_ack_o}, {31'b0, e.ack});
                    chk("wr_done", {31'b0, fill_done_o}, {31'b0, e.done});
                end
            end else begin
                chk("idle_ben", {30'b0, pal_ben_o}, 0);
                chk("idle_ack", {31'b0, host_ack_o}, 0);
                chk("idle_done", {31'b0, fill_done_o}, 0);
            end
            if (exp_busy.exists(cyc)) chk("busy", {31'b0, fill_busy_o}, {31'b0, exp_busy[cyc]});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i = 0;
        host_req_i = 0; host_addr_i = 0; host_wdata_i = 0;
        fill_start_i = 0; fill_first_i = 0; fill_last_i = 0; fill_value_i = 0;
        m_ack = 0; m_busy = 0; m_val = 0;
        #3;
        chk("init_wr_en", {31'b0, pal_wr_en_o}, 0);
        chk("init_busy", {31'b0, fill_busy_o}, 0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_n_i = 1;
        mon_en = 1;

        // host byte lanes, then a held request
        step(1, 9'h005, 8'hAB, 0, 0, 0, 0);
        idle(2);
        step(1, 9'h004, 8'h12, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 6; i++) step(1, 9'(9'h010 + i), 8'(8'h30 + i), 0, 0, 0, 0);
        idle(3);

        // plain, wrapping and full-range fills
        fill(8'h10, 8'h13, 16'h0F00); idle(6);
        fill(8'd250, 8'd3, 16'h1234); idle(12);
        fill(8'd0, 8'd255, 16'hBEEF); idle(258);
        fill(8'd8, 8'd7, 16'hCAFE); idle(258);
        fill(8'h55, 8'h55, 16'h0001); idle(3);

        // host collisions at fill cycles 2 and 4
        fill(8'd0, 8'd7, 16'h7777);
        step(1, 9'h101, 8'h5A, 0, 0, 0, 0);
        step(0, 9'h0, 8'h0, 0, 0, 0, 0);
        step(1, 9'h0E0, 8'hC3, 0, 0, 0, 0);
        idle(10);

        // start while busy is ignored
        fill(8'h20, 8'h2F, 16'hAAAA);
        idle(3);
        step(0, 9'h0, 8'h0, 1, 8'h90, 8'h91, 16'h5555);
        idle(16);

        // reset mid-fill, then a fresh fill
        fill(8'h40, 8'h7F, 16'h4040);
        idle(5);
        do_reset();
        idle(4);
        fill(8'h01, 8'h03, 16'h0303); idle(6);

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            logic [7:0] f;
            f = 8'($urandom);
            step(($urandom_range(0, 99) < 30), 9'($urandom), 8'($urandom),
                 ($urandom_range(0, 99) < 15), f,
                 ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(f + $urandom_range(0, 12)),
                 16'($urandom));
        end
        idle(300);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
